// File: rtl/gfx_pkg.sv
// Shared types, constants and the RGB332 expansion helper used by the
// palette output stage.
package gfx_pkg;

   typedef logic [7:0] pal_entry_t;

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } rgb888_t;

   localparam logic [15:0] PAL_BASE_DEFAULT     = 16'h1400;
   localparam logic [15:0] IRQ_ACK_ADDR_DEFAULT = 16'h1800;

   // Idle level of the sync bundle {hs, vs, blank_n}: syncs high, blanked.
   localparam logic [2:0] SYNC_IDLE = 3'b110;

   localparam pal_entry_t PAL_DEFAULT [8] = '{
      8'h00, 8'hE0, 8'h1C, 8'hFF, 8'h00, 8'hE0, 8'h1C, 8'hFF
   };

   function automatic rgb888_t expand332(input pal_entry_t e);
      rgb888_t c;
      c.r = {e[7:5], e[7:5], e[7:6]};
      c.g = {e[4:2], e[4:2], e[4:3]};
      c.b = {e[1:0], e[1:0], e[1:0], e[1:0]};
      return c;
   endfunction

endpackage

// File: rtl/palette_output_stage_if.sv
// CPU bus seen by the palette output stage: active-low strobes, address,
// write data and registered read data.
interface palette_output_stage_if;

   logic        we_l;
   logic        cs_l;
   logic [15:0] addr;
   logic [7:0]  data_in;
   logic [7:0]  data_out;

   modport master (
      output we_l, cs_l, addr, data_in,
      input  data_out
   );

   modport slave (
      input  we_l, cs_l, addr, data_in,
      output data_out
   );

endinterface

// File: rtl/sync_delay.sv
// Shift register that delays the {hs, vs, blank_n} bundle by DEPTH cycles
// so sync lines up with the pixel-lookup latency.
module sync_delay
   import gfx_pkg::*;
#(
   parameter int unsigned DEPTH = 1
) (
   input  logic clk,
   input  logic reset,
   input  logic hs_i,
   input  logic vs_i,
   input  logic blank_n_i,
   output logic hs_o,
   output logic vs_o,
   output logic blank_n_o
);

   logic [2:0] stage_q [DEPTH];

   // Delay line; reset fills every stage with the idle bundle.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            stage_q[i] <= SYNC_IDLE;
         end
      end else begin
         stage_q[0] <= {hs_i, vs_i, blank_n_i};
         for (int i = 1; i < DEPTH; i++) begin
            stage_q[i] <= stage_q[i-1];
         end
      end
   end

   assign {hs_o, vs_o, blank_n_o} = stage_q[DEPTH-1];

endmodule

// File: rtl/palette_output_stage.sv
// Final graphics stage: palette lookup with shadow/active double buffering,
// sync realignment, registered VGA outputs, frame counter and vblank irq.
module palette_output_stage
   import gfx_pkg::*;
#(
   parameter int unsigned SYNC_DELAY   = 1,
   parameter logic [15:0] PAL_BASE     = PAL_BASE_DEFAULT,
   parameter logic [15:0] IRQ_ACK_ADDR = IRQ_ACK_ADDR_DEFAULT
) (
   input  logic                  clk,
   input  logic                  reset,
   palette_output_stage_if.slave bus,
   input  logic [1:0]            color_code,
   input  logic                  mob_sel,
   input  logic                  output_blank,
   input  logic                  hs_in,
   input  logic                  vs_in,
   input  logic                  blank_n_in,
   output logic                  VGA_HS,
   output logic                  VGA_VS,
   output logic                  VGA_BLANK_N,
   output logic [7:0]            VGA_R,
   output logic [7:0]            VGA_G,
   output logic [7:0]            VGA_B,
   output logic                  irq,
   output logic [7:0]            frame_count
);

   pal_entry_t shadow_q [8];
   pal_entry_t shadow_d [8];
   pal_entry_t active_q [8];
   pal_entry_t active_d [8];

   logic       irq_q, irq_d;
   logic [7:0] frame_q, frame_d;
   logic [7:0] data_out_q, data_out_d;
   rgb888_t    rgb_q, rgb_d;
   logic       vs_q, vs_prev_q;
   logic       hs_out_q, vs_out_q, blank_n_out_q;

   logic       hs_dly, vs_dly, blank_n_dly;
   logic       wr_cyc, rd_cyc, pal_hit, ack_hit, vblank_start;
   logic [2:0] pix_idx;

   sync_delay #(
      .DEPTH     (SYNC_DELAY)
   ) u_sync_delay (
      .clk       (clk),
      .reset     (reset),
      .hs_i      (hs_in),
      .vs_i      (vs_in),
      .blank_n_i (blank_n_in),
      .hs_o      (hs_dly),
      .vs_o      (vs_dly),
      .blank_n_o (blank_n_dly)
   );

   // Bus decode and vblank edge detection.
   always_comb begin
      wr_cyc       = ~bus.cs_l & ~bus.we_l;
      rd_cyc       = ~bus.cs_l &  bus.we_l;
      pal_hit      = (bus.addr >= PAL_BASE) && (bus.addr <= (PAL_BASE + 16'd7));
      ack_hit      = (bus.addr == IRQ_ACK_ADDR);
      vblank_start = vs_prev_q & ~vs_q;
      pix_idx      = {mob_sel, color_code};
   end

   // Next state; active copies the pre-write shadow, and a vblank set beats an ack.
   always_comb begin
      shadow_d   = shadow_q;
      active_d   = active_q;
      irq_d      = irq_q;
      frame_d    = frame_q;
      data_out_d = 8'h00;
      rgb_d      = '0;

      if (wr_cyc && pal_hit) begin
         shadow_d[bus.addr[2:0]] = bus.data_in;
      end else begin
         shadow_d = shadow_q;
      end

      if (vblank_start) begin
         active_d = shadow_q;
         frame_d  = frame_q + 8'd1;
         irq_d    = 1'b1;
      end else if (wr_cyc && ack_hit) begin
         irq_d    = 1'b0;
      end else begin
         irq_d    = irq_q;
      end

      if (rd_cyc && pal_hit) begin
         data_out_d = shadow_q[bus.addr[2:0]];
      end else begin
         data_out_d = 8'h00;
      end

      if (output_blank || !blank_n_dly) begin
         rgb_d = '0;
      end else begin
         rgb_d = expand332(active_q[pix_idx]);
      end
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         shadow_q      <= PAL_DEFAULT;
         active_q      <= PAL_DEFAULT;
         irq_q         <= 1'b0;
         frame_q       <= 8'd0;
         data_out_q    <= 8'h00;
         rgb_q         <= '0;
         vs_q          <= 1'b1;
         vs_prev_q     <= 1'b1;
         hs_out_q      <= 1'b1;
         vs_out_q      <= 1'b1;
         blank_n_out_q <= 1'b0;
      end else begin
         shadow_q      <= shadow_d;
         active_q      <= active_d;
         irq_q         <= irq_d;
         frame_q       <= frame_d;
         data_out_q    <= data_out_d;
         rgb_q         <= rgb_d;
         vs_q          <= vs_in;
         vs_prev_q     <= vs_q;
         hs_out_q      <= hs_dly;
         vs_out_q      <= vs_dly;
         blank_n_out_q <= blank_n_dly;
      end
   end

   assign bus.data_out = data_out_q;
   assign VGA_HS       = hs_out_q;
   assign VGA_VS       = vs_out_q;
   assign VGA_BLANK_N  = blank_n_out_q;
   assign VGA_R        = rgb_q.r;
   assign VGA_G        = rgb_q.g;
   assign VGA_B        = rgb_q.b;
   assign irq          = irq_q;
   assign frame_count  = frame_q;

endmodule

// File: doc/palette_output_stage.md
# palette_output_stage

Final stage of the graphics pipeline, downstream of pixel lookup. Takes the 2-bit `colorCode` plus motion-select from pixel lookup and the raw sync/blank from the VGA timing generator, and maps each pixel through an 8-entry CPU-writable palette. It realigns sync with pixel data and drives the VGA pins with registered RGB/HS/VS/BLANK_N. Palette writes go to shadow registers and commit at vertical-blank start, so a frame never tears mid-scan. The block also produces the frame counter and the vblank interrupt for the CPU.

## Interface
- `SYNC_DELAY`, default 1: cycles of delay applied to sync/blank so they align with `colorCode` (pixel-lookup latency).
- `PAL_BASE`, default 16'h1400: base of the 8 palette bytes (`PAL_BASE`..`PAL_BASE+7`).
- `IRQ_ACK_ADDR`, default 16'h1800: a write to this address clears `irq`.
- `clk` in 1: the single system clock.
- `reset` in 1: synchronous, active-high reset.
- `we_l` in 1: CPU write strobe, active low.
- `cs_l` in 1: CPU chip select, active low.
- `addr` in 16: CPU address.
- `data_in` in 8: CPU write data.
- `data_out` out 8: registered palette read data.
- `color_code` in 2: pixel colour index from pixel lookup.
- `mob_sel` in 1: pixel comes from a motion object; selects palette entries 4–7.
- `output_blank` in 1: pixel lies outside the playfield window, already aligned with `color_code`.
- `hs_in`, `vs_in`, `blank_n_in` in 1 each: raw VGA timing, active low.
- `VGA_HS`, `VGA_VS`, `VGA_BLANK_N` out 1 each: aligned sync and blank.
- `VGA_R`, `VGA_G`, `VGA_B` out 8 each: pixel colour.
- `irq` out 1: vblank interrupt, level, held until acknowledged.
- `frame_count` out 8: frame counter.

## Operation
- CPU write cycle: `~cs_l & ~we_l`.
  - `addr` in `PAL_BASE..PAL_BASE+7`: `shadow[addr[2:0]] <= data_in`.
  - `addr == IRQ_ACK_ADDR`: ack.
  - Any other address: ignored.
- CPU read cycle: `~cs_l & we_l` with `addr` in palette range; `data_out <= shadow[addr[2:0]]` next cycle.
  - Every other cycle: `data_out <= 8'h00`.
- Palette entry format is RGB332: R=`d[7:5]`, G=`d[4:2]`, B=`d[1:0]`.
  - Expand to 8 bits by bit replication: R8={r,r,r[2:1]}, G8 likewise, B8={b,b,b,b}.
- Entry select: `idx = {mob_sel, color_code}`.
  - If `output_blank` or delayed `blank_n` is low, RGB = 0 (black).
  - Otherwise RGB = expand(`active[idx]`).
- `vblank_start`: one-cycle pulse on the first cycle the registered `vs_in` is seen 1→0.
- On `vblank_start`:
  - `active[0..7] <= shadow[0..7]`, all 8 entries in the same cycle.
  - `frame_count <= frame_count + 1`, mod 256, wrapping 255→0.
  - `irq <= 1`.
- Simultaneous events:
  - Palette write in the `vblank_start` cycle: shadow takes the new value; active takes the pre-write shadow value. The new value becomes visible after the next vblank.
  - Ack in the `vblank_start` cycle: the set wins and `irq` stays 1.
- Reset values:
  - shadow = active = {00, E0, 1C, FF, 00, E0, 1C, FF}.
  - `irq`=0, `frame_count`=0, `data_out`=0, RGB=0.
  - `VGA_HS`=1, `VGA_VS`=1, `VGA_BLANK_N`=0.
  - Sync delay line filled with HS=1, VS=1, BLANK_N=0.
  - Edge detector's previous-VS register = 1, so no spurious pulse after reset.
- Reset asserted mid-frame takes effect at the next edge and discards pending shadow writes. Operation resumes at the next VS fall.

## Timing
- `color_code`/`mob_sel`/`output_blank` at cycle N → `VGA_R/G/B` at cycle N+1 (one output register).
- `hs_in`/`vs_in`/`blank_n_in` at cycle N → `VGA_HS/VS/BLANK_N` at cycle N+SYNC_DELAY+1, matching the total RGB latency from the VGA counter.
- The blank gating uses sync delayed by `SYNC_DELAY` (pre-output register), so blank and colour leave the output register in the same edge.
- Palette write at edge E → shadow visible on read at E+1 (`data_out` valid after E+2 edge for a read at E+1).
- `vblank_start` occurs 1 cycle after VS fall at `vs_in`.
  - `irq`, `frame_count` and the `active` commit update at that edge.
  - The first pixel using the new palette is the first visible pixel of the next frame.
- Ack write at edge E → `irq`=0 after E (if no coincident set).

## Structure
- Package `gfx_pkg`:
  - `pal_entry_t` (8-bit) and `rgb888_t` typedefs.
  - `PAL_DEFAULT[8]` constant.
  - `expand332()` function.
  - `PAL_BASE`/`IRQ_ACK_ADDR` defaults.
- Sub-module `sync_delay #(DEPTH)`: parameterised shift register for {hs, vs, blank_n}, with reset values {1,1,0}.
- Top holds the shadow/active arrays, bus decode, edge detect, irq/frame logic and output registers.

## Test plan
- Reset, then `color_code`=2, `mob_sel`=0, unblanked → next cycle RGB = 00/FF/00; HS=VS=1, BLANK_N=0 held during reset.
- Write 0x1405←8'h03 mid-frame → read 0x1405 returns 03; `mob_sel`=1, `color_code`=1 still shows E0 red (FF/00/00) until VS fall, then B=FF, R=G=00.
- Toggle VS low → `irq`=1 and `frame_count` 0→1 one cycle later; write 0x1800 → `irq`=0; 256 frames → `frame_count` wraps to 0.
- Write 0x1400←FF in the exact `vblank_start` cycle → entry 0 shows 00 this frame, FF after the next VS fall; ack in the `vblank_start` cycle leaves `irq`=1.
- `SYNC_DELAY`=2: HS pulse at cycle 10 appears at `VGA_HS` at cycle 13; `output_blank`=1 → RGB=0 regardless of palette.
- Assert `reset` mid-frame after shadow writes → shadow and active return to defaults, `irq`=0, no `vblank_start` pulse on release.
